epd_scan_ctrl: RTL

- Parametrised successor to the fixed 800x600 EPD scan timing generator.
- Drives the gate driver (gdoe/gdclk/gdsp) and source driver (sdclk/sdle/sdoe/sdce0/sd) for any panel geometry and source-bus width.
- Runs a programmable number of back-to-back frames per start command.
- Streams pixel words from an upstream valid/ready source onto epd_sd, with underrun detection.

---
 rtl/epd_scan_ctrl_pkg.sv | 34 +++
 rtl/epd_tick_div.sv | 34 +++
 rtl/epd_scan_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/epd_scan_ctrl_pkg.sv
// Shared definitions for the EPD scan controller: state encoding, default
// panel geometry and counter-width helpers.
package epd_scan_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StRowStart = 3'd2,
      StRowData  = 3'd3,
      StRowEnd   = 3'd4
   } state_e;

   // Default geometry matches the original 800x600 panel timing.
   localparam int unsigned DefSdWidth   = 16;
   localparam int unsigned DefClkDiv    = 4;
   localparam int unsigned DefPrescan   = 47;
   localparam int unsigned DefSpvLen    = 16;
   localparam int unsigned DefVActive   = 600;
   localparam int unsigned DefVOverscan = 1;
   localparam int unsigned DefHFp       = 2;
   localparam int unsigned DefHActive   = 100;
   localparam int unsigned DefHBp       = 2;
   localparam int unsigned DefCkvLow    = 1;

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/epd_tick_div.sv
// Clock divider producing the scan tick and the sdclk phase.
module epd_tick_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o,
   output logic phase_d_o
);

   localparam int unsigned DW = $clog2(CLK_DIV);

   logic [DW-1:0] div_q, div_d;

   // Power-of-2 divide lets the counter wrap naturally; clear restarts the tick phase.
   always_comb begin
      div_d = clr_i ? '0 : div_q + 1'b1;
   end

   // Divider count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign tick_o    = (div_q == DW'(CLK_DIV - 1));
   // Next-cycle phase so the registered sdclk lines up with div_q.
   assign phase_d_o = div_d[DW-1];

endmodule

// File: rtl/epd_scan_ctrl.sv
// EPD scan timing generator: gate/source driver control for a programmable
// panel geometry, multi-frame sequencing and pixel streaming.
module epd_scan_ctrl
   import epd_scan_ctrl_pkg::*;
#(
   parameter int unsigned SD_WIDTH   = DefSdWidth,
   parameter int unsigned CLK_DIV    = DefClkDiv,
   parameter int unsigned PRESCAN    = DefPrescan,
   parameter int unsigned SPV_LEN    = DefSpvLen,
   parameter int unsigned V_ACTIVE   = DefVActive,
   parameter int unsigned V_OVERSCAN = DefVOverscan,
   parameter int unsigned H_FP       = DefHFp,
   parameter int unsigned H_ACTIVE   = DefHActive,
   parameter int unsigned H_BP       = DefHBp,
   parameter int unsigned CKV_LOW    = DefCkvLow
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [7:0]          frames,
   output logic                busy,
   output logic                frame_done,
   output logic [7:0]          frame_idx,
   output logic                underrun,
   input  logic [SD_WIDTH-1:0] pix_data,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic                epd_gdoe,
   output logic                epd_gdclk,
   output logic                epd_gdsp,
   output logic                epd_sdclk,
   output logic                epd_sdle,
   output logic                epd_sdoe,
   output logic                epd_sdce0,
   output logic [SD_WIDTH-1:0] epd_sd
);

   localparam int unsigned HW    = cnt_width(max_u(PRESCAN, H_ACTIVE));
   localparam int unsigned VW    = cnt_width(V_ACTIVE + V_OVERSCAN);
   localparam int unsigned VLast = V_ACTIVE + V_OVERSCAN - 1;

   state_e              state_q, state_d;
   logic [HW-1:0]       h_q, h_d, h_last;
   logic [VW-1:0]       v_q, v_d;
   logic [7:0]          rem_q, rem_d;
   logic [7:0]          idx_q, idx_d;
   logic                busy_q;
   logic                underrun_q, underrun_d;
   logic [SD_WIDTH-1:0] sd_q, sd_d;
   logic                gdoe_q, gdoe_d, gdclk_q, gdclk_d, gdsp_q, gdsp_d;
   logic                sdclk_q, sdclk_d, sdle_q, sdle_d, sdoe_q, sdoe_d, sdce0_q, sdce0_d;
   logic                tick, phase_d, accept;

   assign accept = start && (state_q == StIdle) && (frames != 8'd0);

   epd_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_div (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (accept),
      .tick_o    (tick),
      .phase_d_o (phase_d)
   );

   // Last h_cnt value of the current state's dwell.
   always_comb begin
      h_last = '0;
      case (state_q)
         StStart:    h_last = HW'(PRESCAN - 1);
         StRowStart: h_last = HW'(H_FP - 1);
         StRowData:  h_last = HW'(H_ACTIVE - 1);
         StRowEnd:   h_last = HW'(H_BP - 1);
         default:    h_last = '0;
      endcase
   end

   // Scan FSM next state, row/column counters and frame sequencing.
   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      v_d        = v_q;
      rem_d      = rem_q;
      idx_d      = idx_q;
      frame_done = 1'b0;
      if (accept) begin
         state_d = StStart;
         h_d     = '0;
         v_d     = '0;
         rem_d   = frames;
         idx_d   = '0;
      end else if (tick && (state_q != StIdle)) begin
         if (h_q != h_last) begin
            h_d = h_q + 1'b1;
         end else begin
            h_d = '0;
            unique case (state_q)
               StStart:    state_d = StRowStart;
               StRowStart: state_d = StRowData;
               StRowData:  state_d = StRowEnd;
               StRowEnd: begin
                  if (32'(v_q) < VLast) begin
                     v_d     = v_q + 1'b1;
                     state_d = StRowStart;
                  end else begin
                     frame_done = 1'b1;
                     v_d        = '0;
                     rem_d      = rem_q - 8'd1;
                     if (rem_q == 8'd1) begin
                        state_d = StIdle;
                     end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StStart;
                     end
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   // Pixel handshake: request a word on the tick that enters an active data column.
   always_comb begin
      pix_ready  = tick && (state_d == StRowData) && (32'(v_q) < V_ACTIVE);
      sd_d       = sd_q;
      underrun_d = underrun_q;
      if (accept) begin
         underrun_d = 1'b0;
      end
      if (tick) begin
         sd_d = '0;
      end
      if (pix_ready) begin
         if (pix_valid) begin
            sd_d = pix_data;
         end else begin
            underrun_d = 1'b1;
         end
      end
   end

   // Panel control levels, decoded from next state so they register with it.
   always_comb begin
      gdoe_d  = (state_d != StIdle);
      gdsp_d  = !((state_d == StStart) && (32'(h_d) < SPV_LEN));
      sdce0_d = (state_d != StRowData);
      sdclk_d = (state_d == StRowData) && phase_d;
      sdle_d  = (state_d == StRowEnd) && (h_d == HW'(1));
      sdoe_d  = ((state_d == StRowStart) || (state_d == StRowData) || (state_d == StRowEnd))
                && (v_d != '0);
      gdclk_d = 1'b0;
      case (state_d)
         StStart:               gdclk_d = (32'(h_d) & 32'd8) != 32'd0;
         StRowStart, StRowData: gdclk_d = 1'b1;
         StRowEnd:              gdclk_d = (32'(h_d) >= CKV_LOW);
         default:               gdclk_d = 1'b0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         h_q        <= '0;
         v_q        <= '0;
         rem_q      <= '0;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         sd_q       <= '0;
         gdoe_q     <= 1'b0;
         gdclk_q    <= 1'b0;
         gdsp_q     <= 1'b1;
         sdclk_q    <= 1'b0;
         sdle_q     <= 1'b0;
         sdoe_q     <= 1'b0;
         sdce0_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         v_q        <= v_d;
         rem_q      <= rem_d;
         idx_q      <= idx_d;
         busy_q     <= (state_d != StIdle);
         underrun_q <= underrun_d;
         sd_q       <= sd_d;
         gdoe_q     <= gdoe_d;
         gdclk_q    <= gdclk_d;
         gdsp_q     <= gdsp_d;
         sdclk_q    <= sdclk_d;
         sdle_q     <= sdle_d;
         sdoe_q     <= sdoe_d;
         sdce0_q    <= sdce0_d;
      end
   end

   assign busy      = busy_q;
   assign frame_idx = idx_q;
   assign underrun  = underrun_q;
   assign epd_sd    = sd_q;
   assign epd_gdoe  = gdoe_q;
   assign epd_gdclk = gdclk_q;
   assign epd_gdsp  = gdsp_q;
   assign epd_sdclk = sdclk_q;
   assign epd_sdle  = sdle_q;
   assign epd_sdoe  = sdoe_q;
   assign epd_sdce0 = sdce0_q;

endmodule
